// File: rtl/uart_pkg.sv
// uart_pkg -- shared parity modes, FSM state encoding and baud divider helper for the UART blocks.
`default_nettype none

package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef logic [2:0] uart_state_t;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  function automatic int tick_div(input int clk_hz, input int baud, input int os);
    int d;
    d = clk_hz / (baud * os);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// uart_baud_tick -- oversample tick divider with synchronous phase restart. Rev 1.0
`default_nettype none

module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic restart,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      cnt <= '0;
    else if (restart || tick)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);

endmodule

`default_nettype wire

// File: rtl/uart_rx_param.sv
// uart_rx_param -- parametrised oversampling UART receiver with ready/valid output. Rev 1.0
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 majority vote on every bit decision.
`default_nettype none

module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD        = 9600,
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rxd_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 frame_err_o,
  output logic                 parity_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int            TICK_DIV  = tick_div(CLK_FREQ_HZ, BAUD, OVERSAMPLE);
  localparam int            TW        = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic          ODD_PAR   = (PARITY == PAR_ODD);
  localparam logic          HAS_PAR   = (PARITY != PAR_NONE);

  logic                 sync1, rx_s, rx_prev;
  uart_state_t          state;
  logic [TW-1:0]        tcnt;
  logic [3:0]           bitcnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 ferr_acc, perr_acc;
  logic                 fall, tick, at_sample, bit_val, done;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= rxd_i;
      rx_s    <= sync1;
      rx_prev <= rx_s;
    end
  end

  assign fall = (state == ST_IDLE) && rx_prev && !rx_s;

  uart_baud_tick #(.DIV(TICK_DIV)) u_tick (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .restart (fall),
    .tick    (tick)
  );

`ifdef UART_RX_MAJORITY_EN
  // Vote window ends on the decision tick so transition timing matches the single-sample build.
  logic [1:0] hist;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      hist <= 2'b11;
    else if (tick)
      hist <= {hist[0], rx_s};
  end

  assign bit_val = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
  assign bit_val = rx_s;
`endif

  assign at_sample = tick && (tcnt == ((state == ST_START) ? HALF_LAST : BIT_LAST));
  assign done      = at_sample && (state == ST_STOP) && (bitcnt == STOP_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      tcnt     <= '0;
      bitcnt   <= '0;
      shreg    <= '0;
      ferr_acc <= 1'b0;
      perr_acc <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (fall) begin
        state    <= ST_START;
        tcnt     <= '0;
        bitcnt   <= '0;
        ferr_acc <= 1'b0;
        perr_acc <= 1'b0;
      end
    end else if (tick) begin
      if (!at_sample) begin
        tcnt <= tcnt + 1'b1;
      end else begin
        tcnt <= '0;
        case (state)
          ST_START: state <= bit_val ? ST_IDLE : ST_DATA;
          ST_DATA: begin
            shreg  <= {bit_val, shreg[DATA_BITS-1:1]};
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt == DATA_LAST) begin
              bitcnt <= '0;
              state  <= HAS_PAR ? ST_PARITY : ST_STOP;
            end
          end
          ST_PARITY: begin
            perr_acc <= ((^shreg) ^ bit_val) != ODD_PAR;
            state    <= ST_STOP;
          end
          ST_STOP: begin
            if (!bit_val)
              ferr_acc <= 1'b1;
            bitcnt <= bitcnt + 1'b1;
            // Leave at mid-stop so the next start edge is never missed.
            if (bitcnt == STOP_LAST) begin
              bitcnt <= '0;
              state  <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_o       <= '0;
      valid_o      <= 1'b0;
      frame_err_o  <= 1'b0;
      parity_err_o <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      if (done) begin
        if (!valid_o || ready_i) begin
          data_o       <= shreg;
          frame_err_o  <= ferr_acc | !bit_val;
          parity_err_o <= HAS_PAR & perr_acc;
          valid_o      <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

  assign busy_o = (state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param -- scoreboard bench for uart_rx_param (8N1 and 7E1 instances, 16 clocks per bit).
`default_nettype none

module tb_uart_rx_param;

  typedef struct packed {
    logic [15:0] d;
    logic        fe;
    logic        pe;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd_a = 1'b1, rxd_b = 1'b1;
  logic       ready_a = 1'b1, ready_b = 1'b1;
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic       valid_a, ferr_a, perr_a, ovr_a, busy_a;
  logic       valid_b, ferr_b, perr_b, ovr_b, busy_b;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   errors = 0;
  int   checks = 0;
  int   ov_a = 0;
  int   ov_b = 0;

`ifdef UART_RX_MAJORITY_EN
  localparam int GBIT = 3;
`else
  localparam int GBIT = -1;
`endif

  always #5 clk = ~clk;

  uart_rx_param #(
    .CLK_FREQ_HZ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .rxd_i(rxd_a), .data_o(data_a), .valid_o(valid_a),
    .ready_i(ready_a), .frame_err_o(ferr_a), .parity_err_o(perr_a),
    .overrun_o(ovr_a), .busy_o(busy_a)
  );

  uart_rx_param #(
    .CLK_FREQ_HZ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16),
    .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .rxd_i(rxd_b), .data_o(data_b), .valid_o(valid_b),
    .ready_i(ready_b), .frame_err_o(ferr_b), .parity_err_o(perr_b),
    .overrun_o(ovr_b), .busy_o(busy_b)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input int inst, input logic [15:0] d, input logic fe, input logic pe);
    exp_t e;
    e.d  = d;
    e.fe = fe;
    e.pe = pe;
    if (inst == 0) qa.push_back(e);
    else           qb.push_back(e);
  endtask

  // Drives bits[0..9] LSB first, 16 clocks each; optional one-clock inversion mid-bit gbit.
  task automatic send(input int inst, input logic [15:0] bits, input int gbit, input int nclk);
    logic v;
    int   k;
    k = 0;
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < 16; j++) begin
        if (k < nclk) begin
          v = bits[i];
          if (i == gbit && j == 8) v = ~v;
          if (inst == 0) rxd_a = v;
          else           rxd_b = v;
          cyc(1);
          k++;
        end
      end
    end
  endtask

  function automatic logic [15:0] frame8(input logic [7:0] d, input logic stop);
    return {6'b0, stop, d, 1'b0};
  endfunction

  function automatic logic [15:0] frame7(input logic [6:0] d, input logic par, input logic stop);
    return {6'b0, stop, par, d, 1'b0};
  endfunction

  always @(negedge clk) begin
    if (ovr_a) ov_a++;
    if (ovr_b) ov_b++;
    if (valid_a && ready_a) begin
      check("pending_a", 16'(qa.size() > 0), 16'd1);
      if (qa.size() > 0) begin
        ea = qa.pop_front();
        check("data_a", 16'(data_a), ea.d);
        check("ferr_a", 16'(ferr_a), 16'(ea.fe));
        check("perr_a", 16'(perr_a), 16'(ea.pe));
      end
    end
    if (valid_b && ready_b) begin
      check("pending_b", 16'(qb.size() > 0), 16'd1);
      if (qb.size() > 0) begin
        eb = qb.pop_front();
        check("data_b", 16'(data_b), eb.d);
        check("ferr_b", 16'(ferr_b), 16'(eb.fe));
        check("perr_b", 16'(perr_b), 16'(eb.pe));
      end
    end
  end

  initial begin
    cyc(3);
    check("rst_valid", 16'(valid_a), 16'd0);
    check("rst_data", 16'(data_a), 16'd0);
    check("rst_busy", 16'(busy_a), 16'd0);
    check("rst_ferr", 16'(ferr_a), 16'd0);
    check("rst_perr", 16'(perr_a), 16'd0);
    check("rst_ovr", 16'(ovr_a), 16'd0);
    check("rst_valid_b", 16'(valid_b), 16'd0);
    rst = 1'b0;
    cyc(20);

    push(0, 16'hA5, 1'b0, 1'b0);
    send(0, frame8(8'hA5, 1'b1), -1, 160);
    cyc(16);
    check("a5_drained", 16'(qa.size()), 16'd0);

    push(1, 16'h41, 1'b0, 1'b0);
    send(1, frame7(7'h41, 1'b0, 1'b1), -1, 160);
    cyc(16);
    push(1, 16'h41, 1'b0, 1'b1);
    send(1, frame7(7'h41, 1'b1, 1'b1), -1, 160);
    cyc(16);
    check("par_drained", 16'(qb.size()), 16'd0);

    rxd_a = 1'b0;
    cyc(4);
    check("glitch_busy", 16'(busy_a), 16'd1);
    rxd_a = 1'b1;
    cyc(16);
    check("glitch_idle", 16'(busy_a), 16'd0);
    check("glitch_valid", 16'(valid_a), 16'd0);

    push(0, 16'h3C, 1'b1, 1'b0);
    send(0, frame8(8'h3C, 1'b0), -1, 160);
    rxd_a = 1'b1;
    cyc(16);
    push(0, 16'h11, 1'b0, 1'b0);
    send(0, frame8(8'h11, 1'b1), -1, 160);
    cyc(16);
    check("ferr_drained", 16'(qa.size()), 16'd0);

    ready_a = 1'b0;
    ov_a = 0;
    push(0, 16'h01, 1'b0, 1'b0);
    send(0, frame8(8'h01, 1'b1), -1, 160);
    send(0, frame8(8'h02, 1'b1), -1, 160);
    cyc(16);
    check("ovr_data", 16'(data_a), 16'h01);
    check("ovr_valid", 16'(valid_a), 16'd1);
    check("ovr_pulses", 16'(ov_a), 16'd1);
    ready_a = 1'b1;
    cyc(1);
    ready_a = 1'b0;
    cyc(2);
    check("ovr_released", 16'(valid_a), 16'd0);
    check("ovr_drained", 16'(qa.size()), 16'd0);
    ready_a = 1'b1;
    cyc(16);

    send(0, frame8(8'h5A, 1'b1), -1, 16 * 5 + 8);
    check("mid_busy", 16'(busy_a), 16'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_data", 16'(data_a), 16'd0);
    check("mid_rst_valid", 16'(valid_a), 16'd0);
    check("mid_rst_busy", 16'(busy_a), 16'd0);
    rxd_a = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(32);
    push(0, 16'h5A, 1'b0, 1'b0);
    send(0, frame8(8'h5A, 1'b1), GBIT, 160);
    cyc(16);

    check("final_qa", 16'(qa.size()), 16'd0);
    check("final_qb", 16'(qb.size()), 16'd0);
    check("final_ov_b", 16'(ov_b), 16'd0);
    check("final_busy_b", 16'(busy_b), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
